// File: rtl/fc_pkg.sv
// Shared types and fixed-point helpers for FC-layer plumbing blocks.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ser_state_e;

  localparam int FX_MAX_W = 64;

  // Sign-extends an in_w-bit element, aligns its binary point, and keeps out_w bits.
  function automatic logic [FX_MAX_W-1:0] fx_resize(
    input logic [FX_MAX_W-1:0] elem,
    input int                  in_w,
    input int                  in_frac,
    input int                  out_w,
    input int                  out_frac
  );
    logic [FX_MAX_W-1:0] v;
    for (int b = 0; b < FX_MAX_W; b++) begin
      if (b < in_w) begin
        v[b] = elem[b];
      end else begin
        v[b] = elem[in_w-1];
      end
    end
    v = v << (out_frac - in_frac);
    for (int b = 0; b < FX_MAX_W; b++) begin
      if (b >= out_w) begin
        v[b] = 1'b0;
      end else begin
        v[b] = v[b];
      end
    end
    return v;
  endfunction

  function automatic bit fx_params_ok(
    input int in_w,
    input int in_frac,
    input int out_w,
    input int out_frac
  );
    return (in_w >= 1) && (out_w <= FX_MAX_W) && (out_frac >= in_frac) &&
           ((out_w - out_frac) >= (in_w - in_frac));
  endfunction

endpackage

// File: rtl/fc_vec_serializer.sv
// Captures a DIM-element vector in one cycle and streams it element by element,
// widening each element to the downstream fixed-point format.
module fc_vec_serializer
  import fc_pkg::*;
#(
  parameter int DIM      = 8,
  parameter int IN_W     = 8,
  parameter int IN_FRAC  = 7,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 7,
  parameter int MIN_GAP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_dat [DIM-1:0],
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_dat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

  if (!fx_params_ok(IN_W, IN_FRAC, OUT_W, OUT_FRAC)) begin : g_bad_params
    $error("fc_vec_serializer: output format cannot hold input format exactly");
  end

  ser_state_e       r_state;
  logic [IW-1:0]    r_idx;
  logic [GW-1:0]    r_gap;
  logic [IN_W-1:0]  r_buf [DIM-1:0];
  logic [OUT_W-1:0] r_out_dat;
  logic             r_out_valid;
  logic             r_out_last;

  logic             w_last_idx;
  logic [IW-1:0]    w_next_idx;
  logic             w_in_ready;
  logic             w_capture;
  logic [OUT_W-1:0] w_first_dat;
  logic [OUT_W-1:0] w_next_dat;

  assign w_last_idx  = (r_idx == IW'(DIM - 1));
  assign w_next_idx  = r_idx + IW'(1);
  // With no gap required, a new vector is taken on the cycle the last element leaves.
  assign w_in_ready  = !rst && ((r_state == IDLE) ||
                       ((MIN_GAP == 0) && (r_state == SEND) && w_last_idx && out_ready));
  assign w_capture   = in_valid && w_in_ready;
  assign w_first_dat = OUT_W'(fx_resize(64'(in_dat[0]), IN_W, IN_FRAC, OUT_W, OUT_FRAC));
  assign w_next_dat  = OUT_W'(fx_resize(64'(r_buf[w_next_idx]), IN_W, IN_FRAC, OUT_W, OUT_FRAC));

  // Serializer FSM: vector buffer, element index, gap counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_gap       <= '0;
      r_out_dat   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_capture) begin
      r_buf       <= in_dat;
      r_idx       <= '0;
      r_out_dat   <= w_first_dat;
      r_out_valid <= 1'b1;
      r_out_last  <= 1'(DIM == 1);
      r_state     <= SEND;
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
        end
        SEND: begin
          if (out_ready) begin
            if (w_last_idx) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_idx       <= '0;
              // The IDLE cycle that follows counts as the final idle cycle of the gap.
              if (MIN_GAP > 1) begin
                r_gap   <= GW'(1);
                r_state <= GAP;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_idx      <= w_next_idx;
              r_out_dat  <= w_next_dat;
              r_out_last <= (w_next_idx == IW'(DIM - 1));
            end
          end
        end
        GAP: begin
          if (r_gap == GW'(MIN_GAP - 1)) begin
            r_gap   <= '0;
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_dat   = r_out_dat;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fc_vec_serializer.sv
// Directed self-checking bench: one instance with MIN_GAP=0 and one with MIN_GAP=2.
module tb_fc_vec_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_dat [7:0];
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] out_dat;
  logic [7:0]  g_in_dat [7:0];
  logic        g_in_valid, g_in_ready, g_out_valid, g_out_ready, g_out_last;
  logic [15:0] g_out_dat;

  int checks = 0;
  int errors = 0;

  // Element 0 sits in the low byte / low halfword.
  logic [63:0]  v1 = {8'h10, 8'h00, 8'hFF, 8'h01, 8'hC0, 8'h40, 8'h7F, 8'h80};
  logic [127:0] e1 = {16'h0010, 16'h0000, 16'hFFFF, 16'h0001,
                      16'hFFC0, 16'h0040, 16'h007F, 16'hFF80};
  logic [63:0]  v2 = {8'hB8, 8'hA7, 8'h96, 8'h85, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [127:0] e2 = {16'hFFB8, 16'hFFA7, 16'hFF96, 16'hFF85,
                      16'h0044, 16'h0033, 16'h0022, 16'h0011};

  fc_vec_serializer #(.DIM(8), .IN_W(8), .IN_FRAC(7), .OUT_W(16), .OUT_FRAC(7), .MIN_GAP(0)) u_dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  fc_vec_serializer #(.DIM(8), .IN_W(8), .IN_FRAC(7), .OUT_W(16), .OUT_FRAC(7), .MIN_GAP(2)) u_dut_gap (
    .clk(clk), .rst(rst), .in_dat(g_in_dat), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .out_dat(g_out_dat), .out_valid(g_out_valid), .out_ready(g_out_ready), .out_last(g_out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input bit g, input logic [63:0] p);
    for (int k = 0; k < 8; k++) begin
      if (g) g_in_dat[k] = p[8*k +: 8];
      else   in_dat[k]   = p[8*k +: 8];
    end
  endtask

  task automatic check_elem(input bit g, input logic [127:0] e, input int k, input string tag);
    if (g) begin
      check($sformatf("%s_valid%0d", tag, k), 32'(g_out_valid), 32'd1);
      check($sformatf("%s_dat%0d", tag, k), 32'(g_out_dat), 32'(e[16*k +: 16]));
      check($sformatf("%s_last%0d", tag, k), 32'(g_out_last), 32'(k == 7));
    end else begin
      check($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s_dat%0d", tag, k), 32'(out_dat), 32'(e[16*k +: 16]));
      check($sformatf("%s_last%0d", tag, k), 32'(out_last), 32'(k == 7));
    end
  endtask

  initial begin
    // Reset held with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; set_vec(0, v1);
    g_in_valid = 1'b1; g_out_ready = 1'b1; set_vec(1, v1);
    repeat (3) begin
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_dat", 32'(out_dat), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_rdy", 32'(in_ready), 32'd0);
      check("rst_rdy_gap", 32'(g_in_ready), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0; g_in_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_rdy", 32'(in_ready), 32'd1);
    tick();
    check("post_rst_valid2", 32'(out_valid), 32'd0);

    // Single vector
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_elem(0, e1, k, "single");
      tick();
    end
    check("single_end_valid", 32'(out_valid), 32'd0);
    check("single_end_rdy", 32'(in_ready), 32'd1);

    // Back-to-back with no gap
    set_vec(0, v1); in_valid = 1'b1;
    tick();
    set_vec(0, v2);
    for (int k = 0; k < 8; k++) begin
      check_elem(0, e1, k, "b2b_a");
      if (k == 3) check("b2b_rdy_mid", 32'(in_ready), 32'd0);
      if (k == 7) check("b2b_rdy_last", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_elem(0, e2, k, "b2b_b");
      tick();
    end
    check("b2b_end_valid", 32'(out_valid), 32'd0);

    // MIN_GAP=2 instance, second vector held valid throughout
    set_vec(1, v1); g_in_valid = 1'b1;
    tick();
    set_vec(1, v2);
    for (int k = 0; k < 8; k++) begin
      check_elem(1, e1, k, "gap_a");
      if (k == 7) check("gap_rdy_last", 32'(g_in_ready), 32'd0);
      tick();
    end
    check("gap_idle1_valid", 32'(g_out_valid), 32'd0);
    check("gap_idle1_rdy", 32'(g_in_ready), 32'd0);
    tick();
    check("gap_idle2_valid", 32'(g_out_valid), 32'd0);
    check("gap_idle2_rdy", 32'(g_in_ready), 32'd1);
    tick();
    g_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_elem(1, e2, k, "gap_b");
      tick();
    end
    check("gap_end_valid", 32'(g_out_valid), 32'd0);

    // Stall at element 3, with a competing vector offered
    set_vec(0, v1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_elem(0, e1, k, "pre_stall");
      tick();
    end
    out_ready = 1'b0; in_valid = 1'b1; set_vec(0, v2);
    repeat (3) begin
      check_elem(0, e1, 3, "stall");
      check("stall_rdy", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      check_elem(0, e1, k, "resume");
      tick();
    end
    check("stall_end_valid", 32'(out_valid), 32'd0);

    // Reset pulse at element 5
    set_vec(0, v1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    check_elem(0, e1, 5, "pre_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_dat", 32'(out_dat), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    tick();
    check("mid_rst_noresume", 32'(out_valid), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    set_vec(0, v2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_elem(0, e2, k, "after_rst");
      tick();
    end
    check("after_rst_end_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
